// File: rtl/mem_stage.sv
// RV64I memory-access stage: drives the data RAM port, aligns/extends load data and holds one
// registered result for WB. Define MEM_MISALIGN_CHK_EN to trap misaligned accesses.
module mem_stage #(
    parameter int unsigned RAM_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ex_valid,
    output logic        o_ex_ready,
    input  logic [63:0] i_ex_pc,
    input  logic [31:0] i_ex_inst,
    input  logic [63:0] i_ex_alu_res,
    input  logic [63:0] i_ex_store_data,
    input  logic        i_ex_mem_rd,
    input  logic        i_ex_mem_wr,
    input  logic [2:0]  i_ex_funct3,
    input  logic        i_ex_rd_en,
    input  logic [4:0]  i_ex_rd_addr,
    output logic        o_wb_valid,
    input  logic        i_wb_ready,
    output logic [63:0] o_wb_pc,
    output logic [31:0] o_wb_inst,
    output logic [63:0] o_wb_data,
    output logic        o_wb_rd_en,
    output logic [4:0]  o_wb_rd_addr,
    output logic        o_wb_misalign,
    output logic        o_ram_rd_en,
    output logic [63:0] o_ram_rd_addr,
    input  logic [63:0] i_ram_rd_data,
    output logic        o_ram_wr_en,
    output logic [63:0] o_ram_wr_addr,
    output logic [63:0] o_ram_wr_mask,
    output logic [63:0] o_ram_wr_data
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRdWait = 2'd1;
    localparam logic [1:0] StHold   = 2'd2;
    localparam logic [2:0] LatInit  = 3'(RAM_LAT);

    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic [63:0] r_pc;
    logic [31:0] r_inst;
    logic [63:0] r_data;
    logic        r_rd_en;
    logic [4:0]  r_rd_addr;
    logic [5:0]  r_ld_sh;
    logic [2:0]  r_ld_f3;
    logic        r_ram_rd_en;
    logic [63:0] r_ram_rd_addr;
    logic        r_ram_wr_en;
    logic [63:0] r_ram_wr_addr;
    logic [63:0] r_ram_wr_mask;
    logic [63:0] r_ram_wr_data;

    logic [2:0]  w_off;
    logic [5:0]  w_sh;
    logic [63:0] w_addr;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_misalign;
    logic        w_ex_ready;
    logic        w_accept;
    logic [63:0] w_st_mask;
    logic [63:0] w_ld_shift;
    logic [63:0] w_ld_ext;

    assign w_off   = i_ex_alu_res[2:0];
    assign w_sh    = {w_off, 3'b000};
    assign w_addr  = {i_ex_alu_res[63:3], 3'b000};
    assign w_is_ld = i_ex_mem_rd;
    assign w_is_st = i_ex_mem_wr & ~i_ex_mem_rd;

    // Gated by reset so every output reads 0 while reset is asserted.
    assign w_ex_ready = i_rst_n & ((r_state == StIdle) | ((r_state == StHold) & i_wb_ready));
    assign w_accept   = i_ex_valid & w_ex_ready;

`ifdef MEM_MISALIGN_CHK_EN
    always_comb begin
        w_misalign = 1'b0;
        if (w_is_ld | w_is_st) begin
            case (i_ex_funct3[1:0])
                2'b01:   w_misalign = w_off[0];
                2'b10:   w_misalign = |w_off[1:0];
                2'b11:   w_misalign = |w_off;
                default: w_misalign = 1'b0;
            endcase
        end
    end
`else
    assign w_misalign = 1'b0;
`endif

    // Lanes shifted beyond byte 7 fall off the top of the 64-bit mask.
    always_comb begin
        w_st_mask = '1;
        case (i_ex_funct3[1:0])
            2'b00:   w_st_mask = 64'h0000_0000_0000_00FF << w_sh;
            2'b01:   w_st_mask = 64'h0000_0000_0000_FFFF << w_sh;
            2'b10:   w_st_mask = 64'h0000_0000_FFFF_FFFF << w_sh;
            default: w_st_mask = '1;
        endcase
    end

    assign w_ld_shift = i_ram_rd_data >> r_ld_sh;

    always_comb begin
        w_ld_ext = w_ld_shift;
        case (r_ld_f3)
            3'b000:  w_ld_ext = {{56{w_ld_shift[7]}}, w_ld_shift[7:0]};
            3'b001:  w_ld_ext = {{48{w_ld_shift[15]}}, w_ld_shift[15:0]};
            3'b010:  w_ld_ext = {{32{w_ld_shift[31]}}, w_ld_shift[31:0]};
            3'b100:  w_ld_ext = {56'd0, w_ld_shift[7:0]};
            3'b101:  w_ld_ext = {48'd0, w_ld_shift[15:0]};
            3'b110:  w_ld_ext = {32'd0, w_ld_shift[31:0]};
            default: w_ld_ext = w_ld_shift;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_pc          <= '0;
            r_inst        <= '0;
            r_data        <= '0;
            r_rd_en       <= 1'b0;
            r_rd_addr     <= '0;
            r_ld_sh       <= '0;
            r_ld_f3       <= '0;
            r_ram_rd_en   <= 1'b0;
            r_ram_rd_addr <= '0;
            r_ram_wr_en   <= 1'b0;
            r_ram_wr_addr <= '0;
            r_ram_wr_mask <= '0;
            r_ram_wr_data <= '0;
        end else begin
            r_ram_rd_en <= 1'b0;
            r_ram_wr_en <= 1'b0;
            if (w_accept) begin
                r_pc      <= i_ex_pc;
                r_inst    <= i_ex_inst;
                r_rd_addr <= i_ex_rd_addr;
                r_data    <= i_ex_alu_res;
                if (w_is_ld && !w_misalign) begin
                    r_ram_rd_en   <= 1'b1;
                    r_ram_rd_addr <= w_addr;
                    r_ld_sh       <= w_sh;
                    r_ld_f3       <= i_ex_funct3;
                    r_cnt         <= LatInit;
                    r_rd_en       <= i_ex_rd_en;
                    r_state       <= StRdWait;
                end else begin
                    r_rd_en <= i_ex_rd_en & ~w_is_st & ~w_misalign;
                    r_state <= StHold;
                    if (w_is_st && !w_misalign) begin
                        r_ram_wr_en   <= 1'b1;
                        r_ram_wr_addr <= w_addr;
                        r_ram_wr_mask <= w_st_mask;
                        r_ram_wr_data <= i_ex_store_data << w_sh;
                    end
                end
            end else if (r_state == StRdWait) begin
                // Count reaches 0 in the cycle RAM_LAT after the read strobe.
                if (r_cnt == 3'd0) begin
                    r_data  <= w_ld_ext;
                    r_state <= StHold;
                end else begin
                    r_cnt <= r_cnt - 3'd1;
                end
            end else if ((r_state == StHold) && i_wb_ready) begin
                r_state <= StIdle;
            end
        end
    end

`ifdef MEM_MISALIGN_CHK_EN
    logic r_misalign;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_misalign <= 1'b0;
        end else if (w_accept) begin
            r_misalign <= w_misalign;
        end
    end

    assign o_wb_misalign = r_misalign;
`else
    assign o_wb_misalign = 1'b0;
`endif

    assign o_ex_ready    = w_ex_ready;
    assign o_wb_valid    = (r_state == StHold);
    assign o_wb_pc       = r_pc;
    assign o_wb_inst     = r_inst;
    assign o_wb_data     = r_data;
    assign o_wb_rd_en    = r_rd_en;
    assign o_wb_rd_addr  = r_rd_addr;
    assign o_ram_rd_en   = r_ram_rd_en;
    assign o_ram_rd_addr = r_ram_rd_addr;
    assign o_ram_wr_en   = r_ram_wr_en;
    assign o_ram_wr_addr = r_ram_wr_addr;
    assign o_ram_wr_mask = r_ram_wr_mask;
    assign o_ram_wr_data = r_ram_wr_data;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, randomized ops against a byte-level model,
// and hand sequences for backpressure, reset during a load and misaligned access.
module tb_mem_stage;

    localparam int unsigned LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_pc;
    logic [31:0] ex_inst;
    logic [63:0] ex_alu_res;
    logic [63:0] ex_store_data;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic [2:0]  ex_funct3;
    logic        ex_rd_en;
    logic [4:0]  ex_rd_addr;
    logic        wb_valid;
    logic        wb_ready;
    logic [63:0] wb_pc;
    logic [31:0] wb_inst;
    logic [63:0] wb_data;
    logic        wb_rd_en;
    logic [4:0]  wb_rd_addr;
    logic        wb_misalign;
    logic        ram_rd_en;
    logic [63:0] ram_rd_addr;
    logic [63:0] ram_rd_data;
    logic        ram_wr_en;
    logic [63:0] ram_wr_addr;
    logic [63:0] ram_wr_mask;
    logic [63:0] ram_wr_data;
    logic        any_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage #(.RAM_LAT(LAT)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_ex_valid     (ex_valid),
        .o_ex_ready     (ex_ready),
        .i_ex_pc        (ex_pc),
        .i_ex_inst      (ex_inst),
        .i_ex_alu_res   (ex_alu_res),
        .i_ex_store_data(ex_store_data),
        .i_ex_mem_rd    (ex_mem_rd),
        .i_ex_mem_wr    (ex_mem_wr),
        .i_ex_funct3    (ex_funct3),
        .i_ex_rd_en     (ex_rd_en),
        .i_ex_rd_addr   (ex_rd_addr),
        .o_wb_valid     (wb_valid),
        .i_wb_ready     (wb_ready),
        .o_wb_pc        (wb_pc),
        .o_wb_inst      (wb_inst),
        .o_wb_data      (wb_data),
        .o_wb_rd_en     (wb_rd_en),
        .o_wb_rd_addr   (wb_rd_addr),
        .o_wb_misalign  (wb_misalign),
        .o_ram_rd_en    (ram_rd_en),
        .o_ram_rd_addr  (ram_rd_addr),
        .i_ram_rd_data  (ram_rd_data),
        .o_ram_wr_en    (ram_wr_en),
        .o_ram_wr_addr  (ram_wr_addr),
        .o_ram_wr_mask  (ram_wr_mask),
        .o_ram_wr_data  (ram_wr_data)
    );

    assign any_out = |{ex_ready, wb_valid, wb_pc, wb_inst, wb_data, wb_rd_en, wb_rd_addr,
                       wb_misalign, ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr,
                       ram_wr_mask, ram_wr_data};

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic        rd_en;
        logic [63:0] alu;
        logic [63:0] sd;
        logic [63:0] rdata;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rda;
    } op_t;

    typedef struct {
        int          lat;
        int          rd_cnt;
        int          wr_cnt;
        logic        issue_ready;
        logic        ready_bad;
        logic [63:0] rd_addr;
        logic [63:0] wr_addr;
        logic [63:0] mask;
        logic [63:0] wdata;
        logic [63:0] data;
        logic        rd_en;
        logic        mis;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rda;
    } res_t;

    typedef struct {
        op_t         op;
        logic [63:0] e_data;
        logic [63:0] e_mask;
        logic [63:0] e_wdata;
    } tv_t;

    tv_t tv[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic op_t mk(logic rd, logic wr, logic [2:0] f3, logic [63:0] alu,
                               logic [63:0] sd, logic [63:0] rdata);
        op_t o;
        o.rd    = rd;
        o.wr    = wr;
        o.f3    = f3;
        o.rd_en = 1'b1;
        o.alu   = alu;
        o.sd    = sd;
        o.rdata = rdata;
        o.pc    = {$urandom, $urandom};
        o.inst  = $urandom;
        o.rda   = 5'($urandom);
        return o;
    endfunction

    function automatic tv_t mkv(op_t op, logic [63:0] d, logic [63:0] m, logic [63:0] w);
        tv_t t;
        t.op      = op;
        t.e_data  = d;
        t.e_mask  = m;
        t.e_wdata = w;
        return t;
    endfunction

    function automatic res_t blank();
        res_t r;
        r.lat = 0; r.rd_cnt = 0; r.wr_cnt = 0; r.issue_ready = 1'b0; r.ready_bad = 1'b0;
        r.rd_addr = '0; r.wr_addr = '0; r.mask = '0; r.wdata = '0; r.data = '0;
        r.rd_en = 1'b0; r.mis = 1'b0; r.pc = '0; r.inst = '0; r.rda = '0;
        return r;
    endfunction

    // Byte-wise gather from the RAM word, then sign/zero extension by access size.
    function automatic logic [63:0] load_val(logic [63:0] rd, logic [2:0] off, logic [2:0] f3);
        int size;
        logic [63:0] v;
        size = (f3[1:0] == 2'b11) ? 8 : (1 << f3[1:0]);
        v = '0;
        for (int i = 0; i < size; i++)
            if (int'(off) + i < 8) v[8*i +: 8] = rd[8*(int'(off) + i) +: 8];
        if (!f3[2] && size < 8)
            for (int b = 8 * size; b < 64; b++) v[b] = v[8*size-1];
        return v;
    endfunction

    function automatic res_t model(op_t op);
        res_t e;
        int size;
        logic [2:0] off;
        logic ld, st, mis;
        e    = blank();
        ld   = op.rd;
        st   = op.wr & ~op.rd;
        off  = op.alu[2:0];
        size = (op.f3[1:0] == 2'b11) ? 8 : (1 << op.f3[1:0]);
        mis  = 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
        if ((ld || st) && (int'(off) % size != 0)) mis = 1'b1;
`endif
        e.issue_ready = 1'b1;
        e.lat     = (ld && !mis) ? 2 + int'(LAT) : 1;
        e.rd_cnt  = (ld && !mis) ? 1 : 0;
        e.wr_cnt  = (st && !mis) ? 1 : 0;
        e.rd_addr = {op.alu[63:3], 3'b000};
        e.wr_addr = {op.alu[63:3], 3'b000};
        e.data    = (ld && !mis) ? load_val(op.rdata, off, op.f3) : op.alu;
        e.rd_en   = op.rd_en & ~st & ~mis;
        e.mis     = mis;
        e.pc      = op.pc;
        e.inst    = op.inst;
        e.rda     = op.rda;
        for (int l = 0; l < 8; l++) begin
            if (l >= int'(off)) begin
                e.wdata[8*l +: 8] = op.sd[8*(l - int'(off)) +: 8];
                if (l - int'(off) < size) e.mask[8*l +: 8] = 8'hFF;
            end
        end
        if (size == 8) e.mask = '1;
        return e;
    endfunction

    // Starts and ends at a falling edge with the stage idle; wb_ready held high.
    task automatic run_op(input op_t op, output res_t r);
        int rd_cyc;
        logic done;
        r = blank();
        ex_valid = 1'b1; ex_pc = op.pc; ex_inst = op.inst; ex_alu_res = op.alu;
        ex_store_data = op.sd; ex_mem_rd = op.rd; ex_mem_wr = op.wr; ex_funct3 = op.f3;
        ex_rd_en = op.rd_en; ex_rd_addr = op.rda; wb_ready = 1'b1;
        #1 r.issue_ready = ex_ready;
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0; ex_pc = {$urandom, $urandom}; ex_alu_res = {$urandom, $urandom};
        ex_store_data = {$urandom, $urandom}; ex_funct3 = 3'($urandom); ex_mem_rd = 1'b0;
        ex_mem_wr = 1'b0;
        rd_cyc = -100;
        done = 1'b0;
        for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
            if (ram_rd_en) begin
                r.rd_cnt++; rd_cyc = cyc; r.rd_addr = ram_rd_addr;
            end
            if (ram_wr_en) begin
                r.wr_cnt++; r.wr_addr = ram_wr_addr; r.mask = ram_wr_mask; r.wdata = ram_wr_data;
            end
            ram_rd_data = (cyc == rd_cyc + int'(LAT)) ? op.rdata : {$urandom, $urandom};
            if (wb_valid) begin
                r.lat = cyc; r.data = wb_data; r.rd_en = wb_rd_en; r.mis = wb_misalign;
                r.pc = wb_pc; r.inst = wb_inst; r.rda = wb_rd_addr;
                done = 1'b1;
            end else begin
                if (ex_ready) r.ready_bad = 1'b1;
                @(negedge clk);
            end
        end
        @(negedge clk);
    endtask

    task automatic cmp(input string p, input res_t e, input res_t r);
        chk({p, "_issue_ready"}, 64'(r.issue_ready), 64'(e.issue_ready));
        chk({p, "_wait_ready0"}, 64'(r.ready_bad), 64'(1'b0));
        chk({p, "_lat"}, 64'(r.lat), 64'(e.lat));
        chk({p, "_rd_cnt"}, 64'(r.rd_cnt), 64'(e.rd_cnt));
        chk({p, "_wr_cnt"}, 64'(r.wr_cnt), 64'(e.wr_cnt));
        chk({p, "_data"}, r.data, e.data);
        chk({p, "_rd_en"}, 64'(r.rd_en), 64'(e.rd_en));
        chk({p, "_misalign"}, 64'(r.mis), 64'(e.mis));
        chk({p, "_pc"}, r.pc, e.pc);
        chk({p, "_inst"}, 64'(r.inst), 64'(e.inst));
        chk({p, "_rda"}, 64'(r.rda), 64'(e.rda));
        if (e.rd_cnt > 0) chk({p, "_rd_addr"}, r.rd_addr, e.rd_addr);
        if (e.wr_cnt > 0) begin
            chk({p, "_wr_addr"}, r.wr_addr, e.wr_addr);
            chk({p, "_mask"}, r.mask, e.mask);
            chk({p, "_wdata"}, r.wdata, e.wdata);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        op_t  op;
        res_t r, e;

        rst_n = 1'b0; ex_valid = 1'b0; ex_pc = '0; ex_inst = '0; ex_alu_res = '0;
        ex_store_data = '0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_funct3 = '0;
        ex_rd_en = 1'b0; ex_rd_addr = '0; wb_ready = 1'b1; ram_rd_data = '0;

        tv[0]  = mkv(mk(0, 0, 3'b000, 64'h1234, 64'h0, 64'h0), 64'h1234, 64'h0, 64'h0);
        tv[1]  = mkv(mk(0, 1, 3'b000, 64'h1003, 64'hAB, 64'h0), 64'h1003,
                     64'h0000_0000_FF00_0000, 64'h0000_0000_AB00_0000);
        tv[2]  = mkv(mk(1, 0, 3'b000, 64'h2005, 64'h0, 64'h0000_8000_0000_0000),
                     64'hFFFF_FFFF_FFFF_FF80, 64'h0, 64'h0);
        tv[3]  = mkv(mk(1, 0, 3'b100, 64'h2005, 64'h0, 64'h0000_8000_0000_0000),
                     64'h80, 64'h0, 64'h0);
        tv[4]  = mkv(mk(0, 1, 3'b001, 64'h100E, 64'h1234_5678_9ABC_DEF0, 64'h0), 64'h100E,
                     64'hFFFF_0000_0000_0000, 64'hDEF0_0000_0000_0000);
        tv[5]  = mkv(mk(0, 1, 3'b011, 64'h2008, 64'h1122_3344_5566_7788, 64'h0), 64'h2008,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'h1122_3344_5566_7788);
        tv[6]  = mkv(mk(0, 1, 3'b010, 64'h6004, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0), 64'h6004,
                     64'hFFFF_FFFF_0000_0000, 64'hCCCC_DDDD_0000_0000);
        tv[7]  = mkv(mk(1, 0, 3'b010, 64'h3004, 64'h0, 64'h8765_4321_0000_0000),
                     64'hFFFF_FFFF_8765_4321, 64'h0, 64'h0);
        tv[8]  = mkv(mk(1, 0, 3'b110, 64'h3004, 64'h0, 64'h8765_4321_0000_0000),
                     64'h0000_0000_8765_4321, 64'h0, 64'h0);
        tv[9]  = mkv(mk(1, 0, 3'b001, 64'h4002, 64'h0, 64'h0000_0000_7FFF_0000),
                     64'h7FFF, 64'h0, 64'h0);
        tv[10] = mkv(mk(1, 0, 3'b101, 64'h4006, 64'h0, 64'hF00D_0000_0000_0000),
                     64'hF00D, 64'h0, 64'h0);
        tv[11] = mkv(mk(1, 0, 3'b011, 64'h5000, 64'h0, 64'hDEAD_BEEF_CAFE_F00D),
                     64'hDEAD_BEEF_CAFE_F00D, 64'h0, 64'h0);
        tv[12] = mkv(mk(1, 1, 3'b111, 64'h5008, 64'h0, 64'h0123_4567_89AB_CDEF),
                     64'h0123_4567_89AB_CDEF, 64'h0, 64'h0);
        tv[13] = mkv(mk(0, 1, 3'b000, 64'h7007, 64'h55, 64'h0), 64'h7007,
                     64'hFF00_0000_0000_0000, 64'h5500_0000_0000_0000);

        repeat (2) @(negedge clk);
        chk("reset_all_zero", 64'(any_out), 64'(1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ex_ready", 64'(ex_ready), 64'(1'b1));

        for (int i = 0; i < 14; i++) begin
            e = model(tv[i].op);
            e.data = tv[i].e_data;
            if (e.wr_cnt > 0) begin
                e.mask  = tv[i].e_mask;
                e.wdata = tv[i].e_wdata;
            end
            run_op(tv[i].op, r);
            cmp($sformatf("vec%0d", i), e, r);
        end

        // Backpressure: hold result 3 cycles, then release with a new op on the same edge.
        ex_valid = 1'b1; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_funct3 = 3'b000;
        ex_alu_res = 64'h55; ex_pc = 64'hA0; ex_rd_en = 1'b1; wb_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ex_alu_res = 64'h66; ex_pc = 64'hB0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d_valid", i), 64'(wb_valid), 64'(1'b1));
            chk($sformatf("bp%0d_data", i), wb_data, 64'h55);
            chk($sformatf("bp%0d_pc", i), wb_pc, 64'hA0);
            chk($sformatf("bp%0d_ex_ready", i), 64'(ex_ready), 64'(1'b0));
            @(negedge clk);
        end
        wb_ready = 1'b1;
        #1 chk("bp_release_ready", 64'(ex_ready), 64'(1'b1));
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("bp_b2b_valid", 64'(wb_valid), 64'(1'b1));
        chk("bp_b2b_data", wb_data, 64'h66);
        chk("bp_b2b_pc", wb_pc, 64'hB0);
        @(negedge clk);
        chk("bp_drained", 64'(wb_valid), 64'(1'b0));

        // Reset while the load is outstanding; the late read data must be ignored.
        ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_funct3 = 3'b011; ex_alu_res = 64'h8000;
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_rd = 1'b0;
        chk("rstload_rd_en", 64'(ram_rd_en), 64'(1'b1));
        #2 rst_n = 1'b0;
        #1 chk("rstload_all_zero", 64'(any_out), 64'(1'b0));
        ram_rd_data = 64'h1111_2222_3333_4444;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rstload_no_valid%0d", i), 64'(wb_valid), 64'(1'b0));
            chk($sformatf("rstload_no_rd%0d", i), 64'(ram_rd_en), 64'(1'b0));
        end

        // Misaligned LW.
        op = mk(1, 0, 3'b010, 64'h3002, 64'h0, 64'hCAFE_BABE_1234_5678);
        run_op(op, r);
        cmp("misalign", model(op), r);
`ifdef MEM_MISALIGN_CHK_EN
        chk("misalign_flag", 64'(r.mis), 64'(1'b1));
        chk("misalign_no_rd", 64'(r.rd_cnt), 64'd0);
        chk("misalign_rd_en", 64'(r.rd_en), 64'(1'b0));
        chk("misalign_data", r.data, 64'h3002);
`else
        chk("misalign_flag", 64'(r.mis), 64'(1'b0));
        chk("misalign_rd", 64'(r.rd_cnt), 64'd1);
        chk("misalign_data", r.data, 64'hFFFF_FFFF_BABE_1234);
`endif

        for (int i = 0; i < 150; i++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            op = mk(kind == 2 || kind == 3, kind == 1 || kind == 3, 3'($urandom),
                    {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            op.rd_en = 1'($urandom);
            run_op(op, r);
            cmp($sformatf("rnd%0d", i), model(op), r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
